// File: rtl/ex_pkg.sv
// Shared opcode/result-class encodings and the divider state type for the EX-stage MDU.
package ex_pkg;

  localparam logic [7:0] OP_NOP   = 8'b0000_0000;
  localparam logic [7:0] OP_AND   = 8'b0010_0100;
  localparam logic [7:0] OP_OR    = 8'b0010_0101;
  localparam logic [7:0] OP_XOR   = 8'b0010_0110;
  localparam logic [7:0] OP_NOR   = 8'b0010_0111;
  localparam logic [7:0] OP_SLL   = 8'b0111_1100;
  localparam logic [7:0] OP_SRL   = 8'b0000_0010;
  localparam logic [7:0] OP_SRA   = 8'b0000_0011;
  localparam logic [7:0] OP_MOVZ  = 8'b0000_1010;
  localparam logic [7:0] OP_MOVN  = 8'b0000_1011;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011;
  localparam logic [7:0] OP_MADD  = 8'b1010_0110;
  localparam logic [7:0] OP_MADDU = 8'b1010_1000;
  localparam logic [7:0] OP_MSUB  = 8'b1010_1010;
  localparam logic [7:0] OP_MSUBU = 8'b1010_1011;

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_MOVE  = 3'b011;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DIVBY0 = 2'b01,
    BUSY   = 2'b10,
    DONE   = 2'b11
  } div_state_e;

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative restoring divider: one quotient bit per cycle on operand magnitudes,
// signs re-applied on the way out.
module div_iter
  import ex_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          signed_i,
  input  logic [DW-1:0] dividend_i,
  input  logic [DW-1:0] divisor_i,
  input  logic          annul_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [DW-1:0] quotient_o,
  output logic [DW-1:0] remainder_o
);

  localparam int CW = $clog2(DW) + 1;

  div_state_e    state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] rem;
  logic [DW-1:0] quo;
  logic [DW-1:0] dvs;
  logic          neg_q;
  logic          neg_r;
  logic [DW-1:0] mag_a;
  logic [DW-1:0] mag_b;
  logic [DW:0]   trial;

  always_comb begin
    mag_a = (signed_i && dividend_i[DW-1]) ? -dividend_i : dividend_i;
    mag_b = (signed_i && divisor_i[DW-1])  ? -divisor_i  : divisor_i;
    // borrow out of bit DW means the shifted remainder is below the divisor
    trial = {rem, quo[DW-1]} - {1'b0, dvs};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (annul_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            quo   <= mag_a;
            dvs   <= mag_b;
            rem   <= '0;
            cnt   <= '0;
            neg_q <= signed_i && (dividend_i[DW-1] ^ divisor_i[DW-1]);
            neg_r <= signed_i && dividend_i[DW-1];
            state <= (divisor_i == '0) ? DIVBY0 : BUSY;
          end
        end
        DIVBY0: begin
          quo   <= '0;
          rem   <= '0;
          neg_q <= 1'b0;
          neg_r <= 1'b0;
          state <= DONE;
        end
        BUSY: begin
          if (!trial[DW]) begin
            rem <= trial[DW-1:0];
            quo <= {quo[DW-2:0], 1'b1};
          end else begin
            rem <= {rem[DW-2:0], quo[DW-1]};
            quo <= {quo[DW-2:0], 1'b0};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(DW - 1)) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o      = !annul_i && (((state == IDLE) && start_i) || (state == BUSY) || (state == DIVBY0));
    done_o      = !annul_i && (state == DONE);
    quotient_o  = neg_q ? -quo : quo;
    remainder_o = neg_r ? -rem : rem;
  end

endmodule

// File: rtl/ex_mdu.sv
// EX-stage ALU/multiply/divide unit: single-cycle logic, shift, move and mult,
// two-cycle multiply-accumulate, iterative divide with pipeline stall request.
module ex_mdu
  import ex_pkg::*;
#(
  parameter int DW  = 32,
  parameter int RW  = 5,
  parameter int OPW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] aluop_i,
  input  logic [2:0]     alusel_i,
  input  logic [DW-1:0]  reg1_i,
  input  logic [DW-1:0]  reg2_i,
  input  logic [RW-1:0]  wd_i,
  input  logic           wreg_i,
  input  logic [DW-1:0]  hi_i,
  input  logic [DW-1:0]  lo_i,
  input  logic           mem_whilo_i,
  input  logic [DW-1:0]  mem_hi_i,
  input  logic [DW-1:0]  mem_lo_i,
  input  logic           wb_whilo_i,
  input  logic [DW-1:0]  wb_hi_i,
  input  logic [DW-1:0]  wb_lo_i,
  input  logic           annul_i,
  output logic           stallreq_o,
  output logic           wreg_o,
  output logic [RW-1:0]  wd_o,
  output logic [DW-1:0]  wdata_o,
  output logic           whilo_o,
  output logic [DW-1:0]  hi_o,
  output logic [DW-1:0]  lo_o
);

  localparam int SHW = $clog2(DW);

  logic [7:0]      op;
  logic [SHW-1:0]  sh;
  logic [DW-1:0]   hi_f, lo_f;
  logic [DW-1:0]   logic_res, shift_res, move_res, wdata_c;
  logic [DW-1:0]   hi_c, lo_c;
  logic            whilo_c, stall_c, wreg_c;
  logic            is_mul, is_madd, is_div, mul_signed, madd_sub;
  logic [2*DW-1:0] ext_a, ext_b, prod, acc;
  logic            madd_st;
  logic [2*DW-1:0] prod_r;
  logic            div_busy, div_done;
  logic [DW-1:0]   div_q, div_r;

  assign op = 8'(aluop_i);
  assign sh = reg1_i[SHW-1:0];

  always_comb begin
    if (mem_whilo_i) begin
      hi_f = mem_hi_i;
      lo_f = mem_lo_i;
    end else if (wb_whilo_i) begin
      hi_f = wb_hi_i;
      lo_f = wb_lo_i;
    end else begin
      hi_f = hi_i;
      lo_f = lo_i;
    end
  end

  always_comb begin
    is_mul     = (op == OP_MULT) || (op == OP_MULTU);
    is_madd    = op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    is_div     = is_div_op(op);
    mul_signed = op inside {OP_MULT, OP_MADD, OP_MSUB};
    madd_sub   = op inside {OP_MSUB, OP_MSUBU};
    // extending to full width first makes one multiplier serve both signednesses
    ext_a      = mul_signed ? {{DW{reg1_i[DW-1]}}, reg1_i} : {{DW{1'b0}}, reg1_i};
    ext_b      = mul_signed ? {{DW{reg2_i[DW-1]}}, reg2_i} : {{DW{1'b0}}, reg2_i};
    prod       = ext_a * ext_b;
    acc        = madd_sub ? ({hi_f, lo_f} - prod_r) : ({hi_f, lo_f} + prod_r);
  end

  always_comb begin
    logic_res = '0;
    case (op)
      OP_AND:  logic_res = reg1_i & reg2_i;
      OP_OR:   logic_res = reg1_i | reg2_i;
      OP_XOR:  logic_res = reg1_i ^ reg2_i;
      OP_NOR:  logic_res = ~(reg1_i | reg2_i);
      default: logic_res = '0;
    endcase

    shift_res = '0;
    case (op)
      OP_SLL:  shift_res = reg2_i << sh;
      OP_SRL:  shift_res = reg2_i >> sh;
      OP_SRA:  shift_res = $unsigned($signed(reg2_i) >>> sh);
      default: shift_res = '0;
    endcase

    move_res = '0;
    case (op)
      OP_MOVZ, OP_MOVN: move_res = reg1_i;
      OP_MFHI:          move_res = hi_f;
      OP_MFLO:          move_res = lo_f;
      default:          move_res = '0;
    endcase

    case (alusel_i)
      SEL_LOGIC: wdata_c = logic_res;
      SEL_SHIFT: wdata_c = shift_res;
      SEL_MOVE:  wdata_c = move_res;
      default:   wdata_c = '0;
    endcase

    wreg_c = wreg_i;
    if ((op == OP_MOVN) && (reg2_i == '0)) wreg_c = 1'b0;
    if ((op == OP_MOVZ) && (reg2_i != '0)) wreg_c = 1'b0;
  end

  always_comb begin
    whilo_c = 1'b0;
    stall_c = 1'b0;
    hi_c    = '0;
    lo_c    = '0;
    if (is_mul) begin
      whilo_c      = 1'b1;
      {hi_c, lo_c} = prod;
    end else if (is_madd) begin
      if (!madd_st) begin
        stall_c = 1'b1;
      end else begin
        whilo_c      = 1'b1;
        {hi_c, lo_c} = acc;
      end
    end else if (is_div) begin
      stall_c = div_busy;
      if (div_done) begin
        whilo_c = 1'b1;
        hi_c    = div_r;
        lo_c    = div_q;
      end
    end else if (op == OP_MTHI) begin
      whilo_c = 1'b1;
      hi_c    = reg1_i;
      lo_c    = lo_f;
    end else if (op == OP_MTLO) begin
      whilo_c = 1'b1;
      hi_c    = hi_f;
      lo_c    = reg1_i;
    end
    if (annul_i) begin
      whilo_c = 1'b0;
      stall_c = 1'b0;
      hi_c    = '0;
      lo_c    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      madd_st <= 1'b0;
      prod_r  <= '0;
    end else if (annul_i || !is_madd) begin
      madd_st <= 1'b0;
    end else if (!madd_st) begin
      madd_st <= 1'b1;
      prod_r  <= prod;
    end else begin
      madd_st <= 1'b0;
    end
  end

  div_iter #(.DW(DW)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (is_div),
    .signed_i   (op == OP_DIV),
    .dividend_i (reg1_i),
    .divisor_i  (reg2_i),
    .annul_i    (annul_i),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_q),
    .remainder_o(div_r)
  );

  always_comb begin
    stallreq_o = rst && stall_c;
    wreg_o     = rst && wreg_c;
    wd_o       = rst ? wd_i    : '0;
    wdata_o    = rst ? wdata_c : '0;
    whilo_o    = rst && whilo_c;
    hi_o       = rst ? hi_c    : '0;
    lo_o       = rst ? lo_c    : '0;
  end

endmodule
